// File: rtl/ds_scan_ctrl.sv
// Frame-scan sequencer for the downscale datapath: raster source reads, power-of-two
// decimation keep flags aligned to the BRAM read latency, and destination write control.
module ds_scan_ctrl #(
    parameter int SRC_W_LOG2 = 8,
    parameter int SRC_H_LOG2 = 8,
    parameter int BRAM_LAT   = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [1:0]                       scale_sel,
    input  logic                             out_ready,
    output logic [SRC_W_LOG2+SRC_H_LOG2-1:0] src_addr,
    output logic                             src_rd_en,
    output logic [SRC_W_LOG2+SRC_H_LOG2-1:0] dst_addr,
    output logic                             dst_we,
    output logic                             busy,
    output logic                             done
);

    localparam int AW = SRC_W_LOG2 + SRC_H_LOG2;
    localparam int DW = (BRAM_LAT > 1) ? $clog2(BRAM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state, state_nxt;
    logic [SRC_W_LOG2-1:0] x;
    logic [SRC_H_LOG2-1:0] y;
    logic [1:0]            k_lat;
    logic [AW-1:0]         dst_cnt;
    logic [DW-1:0]         drain_cnt;
    logic [BRAM_LAT-1:0]   vld_p;
    logic                  keep_p0;
    logic                  adv;
    logic                  frame_last;
    logic                  drain_last;

    // Keep one pixel per 2^k x 2^k block: the top-left one.
    function automatic logic keep_pixel(input logic [2:0] px, input logic [2:0] py,
                                        input logic [1:0] k);
        logic [2:0] mask;
        mask = 3'((4'd1 << k) - 4'd1);
        return ((px & mask) == 3'd0) && ((py & mask) == 3'd0);
    endfunction

    assign adv        = out_ready && ((state == RUN) || (state == DRAIN));
    assign frame_last = (&x) && (&y);
    assign drain_last = (drain_cnt == DW'(BRAM_LAT - 1));
    assign keep_p0    = (state == RUN) && keep_pixel(x[2:0], y[2:0], k_lat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (out_ready && frame_last) state_nxt = DRAIN;
            DRAIN:   if (out_ready && drain_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        src_rd_en = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            RUN: begin
                src_rd_en = out_ready;
                busy      = 1'b1;
            end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Stage p0: raster position of the address being issued this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x     <= '0;
            y     <= '0;
            k_lat <= 2'd0;
        end else if ((state == IDLE) && start) begin
            x     <= '0;
            y     <= '0;
            k_lat <= scale_sel;
        end else if ((state == RUN) && out_ready) begin
            x <= x + 1'b1;
            if (&x) y <= y + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           drain_cnt <= '0;
        else if ((state == DRAIN) && out_ready) drain_cnt <= drain_last ? '0 : drain_cnt + 1'b1;
    end

    // Stages p1..pLAT: keep flag tracks the BRAM read, advancing only when the sink accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   vld_p <= '0;
        else if (adv) vld_p <= BRAM_LAT'({vld_p, keep_p0});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      dst_cnt <= '0;
        else if ((state == IDLE) && start) dst_cnt <= '0;
        else if (dst_we)                 dst_cnt <= dst_cnt + 1'b1;
    end

    assign src_addr = {y, x};
    assign dst_addr = dst_cnt;
    assign dst_we   = vld_p[BRAM_LAT-1] & adv;

endmodule

// File: tb/tb_ds_scan_ctrl.sv
// Randomized bench for ds_scan_ctrl: a raster/decimation reference model predicts
// the kept source pixels, which are matched to each destination write.
module tb_ds_scan_ctrl;

    localparam int WL  = 5;
    localparam int HL  = 4;
    localparam int LAT = 2;
    localparam int W   = 1 << WL;
    localparam int H   = 1 << HL;
    localparam int N   = W * H;
    localparam int AW  = WL + HL;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    scale_sel = 2'd0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] src_addr;
    logic          src_rd_en;
    logic [AW-1:0] dst_addr;
    logic          dst_we;
    logic          busy;
    logic          done;

    int n_vec = 0;
    int n_err = 0;

    bit            mon_en = 1'b0;
    int            issue_cnt, wr_cnt, adv_cnt, busy_cnt, done_cnt;
    int            hist[$];
    int            exp_q[$];
    bit            prev_stall;
    logic [AW-1:0] prev_src, prev_dst;

    always #5 clk = ~clk;

    ds_scan_ctrl #(
        .SRC_W_LOG2(WL),
        .SRC_H_LOG2(HL),
        .BRAM_LAT  (LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .scale_sel(scale_sel),
        .out_ready(out_ready),
        .src_addr (src_addr),
        .src_rd_en(src_rd_en),
        .dst_addr (dst_addr),
        .dst_we   (dst_we),
        .busy     (busy),
        .done     (done)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Per-cycle observer: each advancing cycle is one slot in the history of issued reads;
    // a write must belong to the read issued LAT advancing slots earlier.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) begin
                check_val("src_hold", int'(src_addr), int'(prev_src));
                check_val("dst_hold", int'(dst_addr), int'(prev_dst));
            end
            if (!out_ready) check_val("we_in_stall", int'(dst_we), 0);
            if (busy) busy_cnt++;
            check_val("rd_en", int'(src_rd_en), int'(busy && out_ready && (issue_cnt < N)));
            if (dst_we) begin
                check_val("dst_addr", int'(dst_addr), wr_cnt);
                if (hist.size() < LAT)      check_val("we_early", hist.size(), LAT);
                else if (exp_q.size() == 0) check_val("we_extra", exp_q.size(), 1);
                else                        check_val("we_src", hist[hist.size()-LAT], exp_q.pop_front());
                wr_cnt++;
            end
            if (busy && out_ready) begin
                adv_cnt++;
                if (src_rd_en) begin
                    check_val("src_addr", int'(src_addr), issue_cnt);
                    hist.push_back(int'(src_addr));
                    issue_cnt++;
                end else begin
                    hist.push_back(-1);
                end
            end
            if (done) begin
                done_cnt++;
                check_val("busy_at_done", int'(busy), 0);
                check_val("adv_at_done", adv_cnt, N + LAT);
            end
            prev_stall = busy && !out_ready;
            prev_src   = src_addr;
            prev_dst   = dst_addr;
        end
    end

    task automatic run_frame(input int k, input int rdy_pct, input bit inject);
        int exp_n;
        bit got_done;
        exp_q.delete();
        hist.delete();
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
                if ((xx % (1 << k) == 0) && (yy % (1 << k) == 0)) exp_q.push_back(yy * W + xx);
        exp_n      = exp_q.size();
        issue_cnt  = 0;
        wr_cnt     = 0;
        adv_cnt    = 0;
        busy_cnt   = 0;
        done_cnt   = 0;
        prev_stall = 1'b0;
        mon_en     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b1;
        scale_sel = 2'(k);
        out_ready = 1'b1;
        @(posedge clk); #1;
        start    = inject;
        got_done = 1'b0;
        for (int c = 0; (c < 40 * N) && !got_done; c++) begin
            out_ready = ($urandom_range(99) < rdy_pct);
            if (inject) scale_sel = 2'($urandom);
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
        check_val("done_seen", int'(got_done), 1);
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check_val("idle_busy", int'(busy), 0);
        check_val("done_count", done_cnt, 1);
        check_val("write_count", wr_cnt, exp_n);
        check_val("issue_count", issue_cnt, N);
        if (rdy_pct >= 100) check_val("busy_cycles", busy_cnt, N + LAT);
        mon_en = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_busy"}, int'(busy), 0);
        check_val({tag, "_done"}, int'(done), 0);
        check_val({tag, "_we"}, int'(dst_we), 0);
        check_val({tag, "_rd"}, int'(src_rd_en), 0);
        check_val({tag, "_src"}, int'(src_addr), 0);
        check_val({tag, "_dst"}, int'(dst_addr), 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        out_ready = 1'b1;
        #20 check_quiet("reset");
        #10 rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom);
            scale_sel = 2'($urandom);
            @(negedge clk);
            check_quiet("idle");
        end

        run_frame(0, 100, 1'b0);
        run_frame(3, 100, 1'b0);
        run_frame(1, 50, 1'b0);
        run_frame(2, 70, 1'b1);
        run_frame(0, 40, 1'b1);
        for (int f = 0; f < 3; f++)
            run_frame(int'($urandom_range(3)), int'($urandom_range(30, 100)), f[0]);

        // Asynchronous reset in the middle of a frame.
        @(posedge clk); #1;
        start     = 1'b1;
        scale_sel = 2'd0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        for (int c = 0; (c < 4 * N) && (int'(src_addr) != 100); c++) @(negedge clk);
        check_val("abort_reach", int'(src_addr), 100);
        #2 rst_n = 1'b0;
        #1 check_quiet("abort");
        repeat (3) begin
            @(negedge clk);
            check_quiet("in_reset");
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_quiet("post_reset");
        end
        run_frame(2, 80, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
